truth_table_lut_seq: RTL and testbench
======================================

Name: truth_table_lut_seq

Overview:
- Parametrised, runtime-programmable N-input truth-table evaluator for genetic-circuit logic specifications.
- The 2^N-bit truth-table ID is loaded serially and committed atomically. Input vectors are then evaluated through a registered, back-pressured output stage.
- A built-in sweep mode emits every row in order, so downstream scoring and characterisation logic can consume the whole table without a host driving inputs.
- Replaces the fixed per-function truth-table modules in the gate-assignment flow.

Parameters:
- N_IN, 3, number of logic inputs (1..6); TT_W = 2**N_IN is derived internally.
- INIT, {TT_W{1'b0}}, table contents after reset; bit k = output for input address k.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- cfg_valid  input  1  serial config bit valid.
- cfg_ready  output  1  config bit accepted when cfg_valid && cfg_ready.
- cfg_bit  input  1  truth-table ID bit; the ID is streamed MSB-first (first bit = row 0).
- cfg_done  output  1  one-cycle pulse, the cycle after a new table is committed.
- loaded  output  1  high once any full table has been committed since reset.
- in_valid  input  1  input vector valid.
- in_ready  output  1  input vector accepted when in_valid && in_ready.
- in_vec  input  N_IN  address; in_vec[N_IN-1] = in1 (MSB), in_vec[0] = in_N.
- sweep_start  input  1  request a full-table sweep.
- sweep_busy  output  1  high while sweeping.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_bit  output  1  table[address].
- out_addr  output  N_IN  address that produced out_bit.
- table_out  output  TT_W  committed table readback.

Behaviour:
- States: IDLE, LOAD, SWEEP.
- Reset values:
  - Table = INIT; shadow register, bit counter and sweep counter = 0.
  - State = IDLE.
  - out_valid = 0, out_bit = 0, out_addr = 0.
  - cfg_done = 0, loaded = 0, sweep_busy = 0.
- Reset mid-operation: a reset during LOAD discards the partial shadow; a reset during SWEEP drops all pending rows.
- Output register:
  - Single-entry buffer.
  - It may load when !out_valid || out_ready.
  - out_valid clears when out_ready is high and no new load occurs.
  - out_bit and out_addr are held stable while out_valid && !out_ready.
- IDLE priority, one action per cycle: cfg_valid, then sweep_start, then in_valid.
- cfg_ready = (state == IDLE || state == LOAD).
- in_ready = IDLE && !cfg_valid && !sweep_start && (!out_valid || out_ready).
- Evaluate: an accepted in_vec produces out_valid = 1 on the next cycle, with out_bit = table[in_vec] and out_addr = in_vec (latency 1).
- LOAD:
  - The first accepted cfg bit in IDLE enters LOAD with counter = 1.
  - Each accepted bit shifts into the shadow: shadow <= {cfg_bit, shadow[TT_W-1:1]}.
  - On the TT_W-th accepted bit, the table is set to the final shadow value in one edge, then the block returns to IDLE.
  - cfg_done pulses the next cycle and loaded is set.
  - Evaluation never sees a partial table.
  - Bits are counted only on accepted handshakes; gaps in cfg_valid are allowed.
  - in_ready and sweep_start are ignored in LOAD.
  - Results already in the output register drain normally.
- SWEEP:
  - sweep_start accepted in IDLE sets sweep_busy = 1 and counter = 0.
  - Each cycle the output register can load, it loads row counter (out_addr = counter, out_bit = table[counter]), then counter increments.
  - After loading row TT_W-1 the counter wraps to 0, the state returns to IDLE and sweep_busy falls in the same edge.
  - Back-pressure stalls the sweep without skipping or repeating rows.
  - cfg_ready = 0 and in_ready = 0 during SWEEP.
  - sweep_start while busy is ignored.
- Table contents are unchanged except on the final bit of a load.

Test Plan:
- Reset, N_IN=3, INIT=0; after rst deasserts, evaluate in_vec=3'b101 -> out_valid 1 cycle later, out_bit=0, out_addr=5; loaded=0, table_out=0.
- Stream ID 0x2D MSB-first (0,0,1,0,1,1,0,1) with cfg_valid gaps -> table_out=8'hB4, one cfg_done pulse, loaded=1. Then evaluate 000, 010, 100, 110 -> 0, 1, 1, 0.
- Sweep with out_ready held high -> 8 consecutive outputs, addr 0..7, bits 0,0,1,0,1,1,0,1; sweep_busy high for exactly 8 cycles.
- Sweep with out_ready toggled 1,0,0,1,... -> each address appears exactly once in order; out_bit and out_addr are stable during stalls.
- Assert rst after 5 of 8 cfg bits -> table_out returns to INIT, no cfg_done. A fresh 8-bit load then commits correctly.
- Drive cfg_valid, sweep_start and in_valid in the same IDLE cycle -> only the cfg bit is accepted (in_ready=0, no sweep); state = LOAD.

Source files
------------

// File: rtl/truth_table_lut_seq.sv
// rtl/truth_table_lut_seq.sv - runtime-programmable N-input truth-table evaluator with serial load and sweep
module truth_table_lut_seq #(
  parameter int N_IN = 3,
  parameter logic [(2**N_IN)-1:0] INIT = '0,
  localparam int TT_W = 2**N_IN,
  localparam int CNT_W = N_IN + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic              cfg_bit,
  output logic              cfg_done,
  output logic              loaded,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_IN-1:0]   in_vec,
  input  logic              sweep_start,
  output logic              sweep_busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_bit,
  output logic [N_IN-1:0]   out_addr,
  output logic [TT_W-1:0]   table_out
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SWEEP} state_t;

  state_t            state_q, state_d;
  logic [TT_W-1:0]   table_q, table_d;
  logic [TT_W-1:0]   shadow_q, shadow_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [N_IN-1:0]   sweep_cnt_q, sweep_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic              out_bit_q, out_bit_d;
  logic [N_IN-1:0]   out_addr_q, out_addr_d;
  logic              cfg_done_q, cfg_done_d;
  logic              loaded_q, loaded_d;
  logic              out_can_load;
  logic [TT_W-1:0]   shadow_shift;

  // The output buffer may take a new entry when empty or being drained this cycle.
  assign out_can_load = !out_valid_q || out_ready;
  // Incoming config bits enter at the top so the first streamed bit ends up at row 0.
  assign shadow_shift = {cfg_bit, shadow_q[TT_W-1:1]};

  assign cfg_ready  = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign in_ready   = (state_q == S_IDLE) && !cfg_valid && !sweep_start && out_can_load;
  assign sweep_busy = (state_q == S_SWEEP);
  assign cfg_done   = cfg_done_q;
  assign loaded     = loaded_q;
  assign out_valid  = out_valid_q;
  assign out_bit    = out_bit_q;
  assign out_addr   = out_addr_q;
  assign table_out  = table_q;

  // Next-state logic: IDLE arbitration, serial load with atomic commit, and row sweep.
  always_comb begin
    state_d     = state_q;
    table_d     = table_q;
    shadow_d    = shadow_q;
    bit_cnt_d   = bit_cnt_q;
    sweep_cnt_d = sweep_cnt_q;
    cfg_done_d  = 1'b0;
    loaded_d    = loaded_q;
    out_valid_d = out_valid_q && !out_ready;
    out_bit_d   = out_bit_q;
    out_addr_d  = out_addr_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          shadow_d  = shadow_shift;
          bit_cnt_d = CNT_W'(1);
          state_d   = S_LOAD;
        end else if (sweep_start) begin
          sweep_cnt_d = '0;
          state_d     = S_SWEEP;
        end else if (in_valid && in_ready) begin
          out_valid_d = 1'b1;
          out_bit_d   = table_q[in_vec];
          out_addr_d  = in_vec;
        end
      end
      S_LOAD: begin
        if (cfg_valid) begin
          shadow_d = shadow_shift;
          if (bit_cnt_q == CNT_W'(TT_W - 1)) begin
            table_d    = shadow_shift;
            bit_cnt_d  = '0;
            cfg_done_d = 1'b1;
            loaded_d   = 1'b1;
            state_d    = S_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      S_SWEEP: begin
        if (out_can_load) begin
          out_valid_d = 1'b1;
          out_bit_d   = table_q[sweep_cnt_q];
          out_addr_d  = sweep_cnt_q;
          sweep_cnt_d = sweep_cnt_q + N_IN'(1);
          if (sweep_cnt_q == '1) begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      table_q     <= INIT;
      shadow_q    <= '0;
      bit_cnt_q   <= '0;
      sweep_cnt_q <= '0;
      cfg_done_q  <= 1'b0;
      loaded_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      table_q     <= table_d;
      shadow_q    <= shadow_d;
      bit_cnt_q   <= bit_cnt_d;
      sweep_cnt_q <= sweep_cnt_d;
      cfg_done_q  <= cfg_done_d;
      loaded_q    <= loaded_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
      out_addr_q  <= out_addr_d;
    end
  end

endmodule

// File: tb/tb_truth_table_lut_seq.sv
// tb/tb_truth_table_lut_seq.sv - directed self-checking bench for truth_table_lut_seq
module tb_truth_table_lut_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid, cfg_ready, cfg_bit, cfg_done, loaded;
  logic       in_valid, in_ready;
  logic [2:0] in_vec;
  logic       sweep_start, sweep_busy;
  logic       out_valid, out_ready, out_bit;
  logic [2:0] out_addr;
  logic [7:0] table_out;

  int n_assert = 0;
  int n_fail   = 0;

  truth_table_lut_seq #(.N_IN(3), .INIT(8'h00)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_bit(cfg_bit),
    .cfg_done(cfg_done), .loaded(loaded),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .sweep_start(sweep_start), .sweep_busy(sweep_busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
    .out_addr(out_addr), .table_out(table_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic eval_vec(input logic [2:0] v, input logic exp_bit);
    in_valid = 1'b1;
    in_vec   = v;
    #1;
    chk("eval_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("eval_out_valid", out_valid, 1);
    chk("eval_out_bit", out_bit, exp_bit);
    chk("eval_out_addr", out_addr, v);
  endtask

  // Stream tt row 0 first; optional idle gaps after odd bits. Returns cfg_done pulses seen.
  task automatic load_table(input logic [7:0] tt, input logic [7:0] old_tt, input bit gaps,
                            output int dones);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      cfg_valid = 1'b1;
      cfg_bit   = tt[i];
      step();
      dones += int'(cfg_done);
      cfg_valid = 1'b0;
      if (i == 4) chk("no_partial_table", table_out, old_tt);
      if (gaps && i[0]) begin
        step();
        dones += int'(cfg_done);
      end
    end
    for (int i = 0; i < 2; i++) begin
      step();
      dones += int'(cfg_done);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] tt;
    logic [3:0] pat;
    int dones, n, busy_cnt;

    rst = 1'b1; cfg_valid = 0; cfg_bit = 0; in_valid = 0; in_vec = 0;
    sweep_start = 0; out_ready = 1'b1;
    step(); step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_bit", out_bit, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_cfg_done", cfg_done, 0);
    chk("rst_loaded", loaded, 0);
    chk("rst_sweep_busy", sweep_busy, 0);
    chk("rst_table", table_out, 8'h00);
    rst = 1'b0;
    step();
    chk("idle_cfg_ready", cfg_ready, 1);

    // Evaluate against the INIT table
    eval_vec(3'b101, 1'b0);
    chk("init_loaded", loaded, 0);
    chk("init_table", table_out, 8'h00);
    step();
    chk("out_valid_drained", out_valid, 0);

    // Load ID 0x2D (stream 0,0,1,0,1,1,0,1) with gaps -> table 0xB4
    load_table(8'hB4, 8'h00, 1'b1, dones);
    chk("load1_table", table_out, 8'hB4);
    chk("load1_done_pulses", dones, 1);
    chk("load1_loaded", loaded, 1);
    eval_vec(3'b000, 1'b0);
    eval_vec(3'b010, 1'b1);
    eval_vec(3'b100, 1'b1);
    eval_vec(3'b110, 1'b0);
    step();

    // Sweep with out_ready held high
    tt = 8'hB4;
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    chk("sweep_cfg_ready", cfg_ready, 0);
    chk("sweep_in_ready", in_ready, 0);
    n = 0; busy_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (sweep_busy) busy_cnt++;
      if (out_valid) begin
        if (n < 8) begin
          chk("sweep1_addr", out_addr, n);
          chk("sweep1_bit", out_bit, tt[n]);
        end else begin
          chk("sweep1_extra_row", out_valid, 0);
        end
        n++;
      end
      step();
    end
    chk("sweep1_rows", n, 8);
    chk("sweep1_busy_cycles", busy_cnt, 8);

    // Sweep with out_ready pattern 1,0,0,1: rows stay in order and hold during stalls
    pat = 4'b1001;
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      out_ready = pat[k % 4];
      if (out_valid) begin
        if (n < 8) begin
          chk("sweep2_addr", out_addr, n);
          chk("sweep2_bit", out_bit, tt[n]);
        end else begin
          chk("sweep2_extra_row", out_valid, 0);
        end
        if (out_ready) n++;
      end
      step();
    end
    out_ready = 1'b1;
    step();
    chk("sweep2_rows", n, 8);
    chk("sweep2_busy_end", sweep_busy, 0);

    // Reset after 5 of 8 bits discards the partial load
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      cfg_valid = 1'b1;
      cfg_bit   = 1'b1;
      step();
      dones += int'(cfg_done);
    end
    cfg_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    dones += int'(cfg_done);
    step();
    dones += int'(cfg_done);
    chk("midrst_table", table_out, 8'h00);
    chk("midrst_loaded", loaded, 0);
    chk("midrst_no_done", dones, 0);
    load_table(8'hA5, 8'h00, 1'b0, dones);
    chk("load2_table", table_out, 8'hA5);
    chk("load2_done_pulses", dones, 1);
    chk("load2_loaded", loaded, 1);

    // cfg_valid, sweep_start and in_valid together in IDLE: only the cfg bit is taken
    cfg_valid = 1'b1; cfg_bit = 1'b1; sweep_start = 1'b1; in_valid = 1'b1; in_vec = 3'd3;
    #1;
    chk("prio_in_ready", in_ready, 0);
    chk("prio_cfg_ready", cfg_ready, 1);
    step();
    cfg_valid = 1'b0; sweep_start = 1'b0; in_valid = 1'b0;
    #1;
    chk("prio_no_sweep", sweep_busy, 0);
    chk("prio_no_eval", out_valid, 0);
    chk("prio_load_in_ready", in_ready, 0);
    chk("prio_load_cfg_ready", cfg_ready, 1);
    dones = 0;
    for (int i = 1; i < 8; i++) begin
      cfg_valid = 1'b1;
      cfg_bit   = 1'b0;
      step();
      dones += int'(cfg_done);
    end
    cfg_valid = 1'b0;
    step();
    dones += int'(cfg_done);
    chk("prio_table", table_out, 8'h01);
    chk("prio_done_pulses", dones, 1);
    eval_vec(3'b000, 1'b1);
    eval_vec(3'b111, 1'b0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
